// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (instruction/data) arbiter for one shared memory port
// Optional round-robin contention policy enabled by defining ARBITER_FAIR_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_req,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t                state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic                  m_req_q, m_req_d;
  logic                  m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic any_ack;
  logic i_qual;
  logic d_qual;
  logic pick_d;

  // The cycle carrying an ack pulse is always an idle bubble, so a held
  // request is never serviced twice and the loser gets no free slot.
  assign any_ack = i_ack_q | d_ack_q;
  assign i_qual  = i_req & ~any_ack;
  assign d_qual  = d_req & ~any_ack;

`ifdef ARBITER_FAIR_EN
  assign pick_d = d_qual & (~i_qual | (last_grant_q == GRANT_I));
`else
  assign pick_d = d_qual;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          m_req_d      = 1'b1;
          m_write_d    = d_write;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
        end else if (i_qual) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          m_req_d      = 1'b1;
          m_write_d    = 1'b0;
          m_addr_d     = i_addr;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = m_rdata;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          if (!m_write_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      m_req_q      <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch read request, held high until i_ack.
REQ-006 i_addr  in  ADDR_WIDTH  fetch address, stable while i_req high.
REQ-007 i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  out  DATA_WIDTH  fetched word, registered, held until next I completion.
REQ-009 d_req  in  1  data request, held high until d_ack.
REQ-010 d_write  in  1  1 = store, 0 = load; stable while d_req high.
REQ-011 d_addr  in  ADDR_WIDTH  data address.
REQ-012 d_wdata  in  DATA_WIDTH  store data.
REQ-013 d_ack  out  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  out  DATA_WIDTH  load result, registered, held until next D load completion.
REQ-015 m_req  out  1  shared memory port request, registered.
REQ-016 m_write  out  1  shared port write enable.
REQ-017 m_addr  out  ADDR_WIDTH  shared port address.
REQ-018 m_wdata  out  DATA_WIDTH  shared port write data.
REQ-019 m_rdata  in  DATA_WIDTH  shared port read data, valid when m_ack high.
REQ-020 m_ack  in  1  shared port completion, high for one or more cycles; first high cycle completes transaction.

Function
REQ-021 States SHALL be IDLE, BUSY_I, BUSY_D; all outputs SHALL be registered.
REQ-022 IDLE: on edge with a qualifying request, SHALL latch winner's addr/write/wdata onto m_addr/m_write/m_wdata, set m_req=1, enter BUSY_x.
REQ-023 A request SHALL NOT qualify in the cycle its own ack is high (prevents double service of a held req).
REQ-024 I grants SHALL drive m_write=0 and m_wdata unchanged.
REQ-025 BUSY_x: m_req, m_write, m_addr, m_wdata SHALL remain stable until the edge sampling m_ack=1.
REQ-026 On edge sampling m_ack=1 in BUSY_x: m_req←0, x_ack←1 for exactly one cycle, state←IDLE; x_rdata←m_rdata unless D write (d_rdata unchanged).
REQ-027 Latency: req sampled at edge N -> m_req high after N; m_ack sampled at edge K -> x_ack high for cycle after K; minimum req-to-ack 2 cycles.
REQ-028 m_ack while IDLE SHALL be ignored; no ack pulse, no state change.
REQ-029 Requests arriving while BUSY SHALL wait; no preemption; deasserting req before ack is illegal and not checked.
REQ-030 Requests SHALL be re-evaluated in IDLE cycle after a completion, giving one idle bubble between back-to-back transactions.
REQ-031 Register last_grant SHALL record requester of each granted transaction.

Reset
REQ-032 reset high SHALL immediately force state=IDLE, m_req=0, m_write=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, last_grant=I.
REQ-033 Reset mid-transaction SHALL abandon it silently; no ack is ever issued for it.

Configuration
REQ-034 Macro ARBITER_FAIR_EN: when defined, simultaneous I and D requests SHALL be granted to the requester not equal to last_grant (round-robin).
REQ-035 Without ARBITER_FAIR_EN, simultaneous requests SHALL always grant D (fixed data priority); last_grant kept but unused.
REQ-036 Both modes SHALL grant D on first contention after reset.

Verification
REQ-037 i_req=1, i_addr=0x00400000; m_ack=1 two cycles after m_req -> m_addr=0x00400000, m_write=0, i_ack one pulse, i_rdata=m_rdata (0x8C080004).
REQ-038 d_req=1, d_write=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> m_write=1, m_wdata=0xDEADBEEF, d_ack pulse, d_rdata unchanged (0).
REQ-039 i_req and d_req high together, held over 3 transactions -> default: D,(idle),D,...,I never served while d_req held; with ARBITER_FAIR_EN: D, I, D.
REQ-040 reset pulsed while BUSY_D before m_ack -> m_req=0 same cycle, no d_ack; later m_ack=1 in IDLE ignored.
REQ-041 m_ack held high 3 cycles in one transaction -> exactly one ack pulse; next request not granted before its own qualifying IDLE edge.
